// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/stall controller and its helpers.
package pipe_pkg;

    localparam int unsigned OP_W  = 6;
    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // True when the opcode reads rt as a source operand.
    function automatic logic uses_rt(input logic [OP_W-1:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: r = 1'b1;
            default:                         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detection between the IF/ID instruction and a load in ID/EX.
// Ports: op_id/rs_id/rt_id (IF/ID fields), idex_memread/idex_rt (ID/EX load),
//        hz (1 when the IF/ID instruction consumes the load result).
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [OP_W-1:0]  op_id,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    output logic             hz
);

    // $zero is never a real dependency.
    always_comb begin
        hz = idex_memread && (idex_rt != '0) &&
             ((idex_rt == rs_id) || ((idex_rt == rt_id) && uses_rt(op_id)));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and stall controller for IF/ID and the PC: load-use stalls, taken
// branch flushes, memory freezes and a saturating lost-cycle counter.
// Ports: clk_PCTRL/rst_PCTRL (sync active-high reset); IF/ID fields op_id,
//        rs_id, rt_id; ID/EX load info idex_memread, idex_rt; events
//        branch_taken_ex, mem_busy, stat_clr; controls pc_we, ifid_we,
//        ifid_flush, idex_bubble, pipe_hold (combinational); busy_state;
//        stall_count (registered).
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned STAT_W   = 16
) (
    input  logic              clk_PCTRL,
    input  logic              rst_PCTRL,
    input  logic [OP_W-1:0]   op_id,
    input  logic [REG_W-1:0]  rs_id,
    input  logic [REG_W-1:0]  rt_id,
    input  logic              idex_memread,
    input  logic [REG_W-1:0]  idex_rt,
    input  logic              branch_taken_ex,
    input  logic              mem_busy,
    input  logic              stat_clr,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              pipe_hold,
    output logic              busy_state,
    output logic [STAT_W-1:0] stall_count
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STAT_W-1:0]  stall_count_q;
    logic               hz;

    hazard_detect u_hazard_detect (
        .op_id        (op_id),
        .rs_id        (rs_id),
        .rt_id        (rt_id),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .hz           (hz)
    );

    // State and stall-counter registers.
    always_ff @(posedge clk_PCTRL) begin
        if (rst_PCTRL) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: busy freezes everything, branch aborts, then stall sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (mem_busy) begin
            state_d = state_q;
        end else if (branch_taken_ex) begin
            state_d = ST_RUN;
            cnt_d   = '0;
        end else if (state_q == ST_STALL) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = ST_RUN;
            end
        end else if (hz && (LOAD_LAT > 1)) begin
            state_d = ST_STALL;
            cnt_d   = CNT_W'(LOAD_LAT - 1);
        end
    end

    // Control outputs act on the same-cycle edge.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        busy_state  = (state_q == ST_STALL);
        if (rst_PCTRL) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            busy_state  = 1'b0;
        end else if (mem_busy) begin
            pc_we     = 1'b0;
            ifid_we   = 1'b0;
            pipe_hold = 1'b1;
        end else if (branch_taken_ex) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if ((state_q == ST_STALL) || hz) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // Lost-cycle counter; clear wins over the increment.
    always_ff @(posedge clk_PCTRL) begin
        if (rst_PCTRL || stat_clr) begin
            stall_count_q <= '0;
        end else if (!pc_we && (stall_count_q != '1)) begin
            stall_count_q <= stall_count_q + STAT_W'(1);
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (LOAD_LAT=1 / 4-bit stats and
// LOAD_LAT=3 / 16-bit stats) share stimulus and are compared cycle by cycle
// against a remaining-stall-cycles reference model.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [4:0] rs, rt, irt;
    logic       mr, br, busy, clr;

    logic       a_pc_we, a_ifid_we, a_flush, a_bubble, a_hold, a_busy;
    logic [3:0] a_cnt;
    logic       b_pc_we, b_ifid_we, b_flush, b_bubble, b_hold, b_busy;
    logic [15:0] b_cnt;

    int errors = 0;
    int checks = 0;
    int lat[2]    = '{1, 3};
    int cmax[2]   = '{15, 65535};
    int remain[2] = '{0, 0};
    int count[2]  = '{0, 0};

    always #5 clk = ~clk;

    pipe_ctrl #(.LOAD_LAT(1), .STAT_W(4)) u_dut_a (
        .clk_PCTRL(clk), .rst_PCTRL(rst), .op_id(op), .rs_id(rs), .rt_id(rt),
        .idex_memread(mr), .idex_rt(irt), .branch_taken_ex(br), .mem_busy(busy),
        .stat_clr(clr), .pc_we(a_pc_we), .ifid_we(a_ifid_we), .ifid_flush(a_flush),
        .idex_bubble(a_bubble), .pipe_hold(a_hold), .busy_state(a_busy),
        .stall_count(a_cnt)
    );

    pipe_ctrl #(.LOAD_LAT(3), .STAT_W(16)) u_dut_b (
        .clk_PCTRL(clk), .rst_PCTRL(rst), .op_id(op), .rs_id(rs), .rt_id(rt),
        .idex_memread(mr), .idex_rt(irt), .branch_taken_ex(br), .mem_busy(busy),
        .stat_clr(clr), .pc_we(b_pc_we), .ifid_we(b_ifid_we), .ifid_flush(b_flush),
        .idex_bubble(b_bubble), .pipe_hold(b_hold), .busy_state(b_busy),
        .stall_count(b_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Load-use rule straight from the instruction semantics.
    function automatic bit ref_hz();
        bit reads_rt;
        reads_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
        return mr && (irt != 0) && ((irt == rs) || (reads_rt && (irt == rt)));
    endfunction

    // Check the current cycle (inputs set just after negedge), advance the model.
    task automatic step();
        bit e_pc, e_we, e_fl, e_bub, e_hold, e_bs, hz;
        logic [31:0] g_pc, g_we, g_fl, g_bub, g_hold, g_bs, g_cnt;
        string n;
        #1;
        hz = ref_hz();
        for (int i = 0; i < 2; i++) begin
            n = (i == 0) ? "L1" : "L3";
            e_bs = (remain[i] > 0);
            e_hold = 0; e_fl = 0;
            if (rst) begin
                e_pc = 0; e_we = 0; e_fl = 1; e_bub = 1; e_bs = 0;
            end else if (busy) begin
                e_pc = 0; e_we = 0; e_bub = 0; e_hold = 1;
            end else if (br) begin
                e_pc = 1; e_we = 1; e_fl = 1; e_bub = 1;
            end else if (remain[i] > 0 || hz) begin
                e_pc = 0; e_we = 0; e_bub = 1;
            end else begin
                e_pc = 1; e_we = 1; e_bub = 0;
            end
            g_pc   = 32'((i == 0) ? a_pc_we   : b_pc_we);
            g_we   = 32'((i == 0) ? a_ifid_we : b_ifid_we);
            g_fl   = 32'((i == 0) ? a_flush   : b_flush);
            g_bub  = 32'((i == 0) ? a_bubble  : b_bubble);
            g_hold = 32'((i == 0) ? a_hold    : b_hold);
            g_bs   = 32'((i == 0) ? a_busy    : b_busy);
            g_cnt  = (i == 0) ? 32'(a_cnt) : 32'(b_cnt);
            check_eq({n, ".pc_we"},       g_pc,   32'(e_pc));
            check_eq({n, ".ifid_we"},     g_we,   32'(e_we));
            check_eq({n, ".ifid_flush"},  g_fl,   32'(e_fl));
            check_eq({n, ".idex_bubble"}, g_bub,  32'(e_bub));
            check_eq({n, ".pipe_hold"},   g_hold, 32'(e_hold));
            check_eq({n, ".busy_state"},  g_bs,   32'(e_bs));
            check_eq({n, ".stall_count"}, g_cnt,  32'(count[i]));
            if (rst) begin
                remain[i] = 0;
                count[i]  = 0;
            end else begin
                if (!busy) begin
                    if (br)                remain[i] = 0;
                    else if (remain[i] > 0) remain[i] = remain[i] - 1;
                    else if (hz)           remain[i] = lat[i] - 1;
                end
                if (clr)        count[i] = 0;
                else if (!e_pc) count[i] = (count[i] >= cmax[i]) ? cmax[i] : count[i] + 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic cyc(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                       input logic m, input logic [4:0] d, input logic b,
                       input logic bz, input logic c, input logic r);
        op = o; rs = s; rt = t; mr = m; irt = d; br = b; busy = bz; clr = c; rst = r;
        step();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [5:0] ops[6] = '{6'h00, 6'h04, 6'h05, 6'h2B, 6'h23, 6'h08};

    initial begin
        op = 0; rs = 0; rt = 0; mr = 0; irt = 0; br = 0; busy = 0; clr = 0; rst = 1;
        @(negedge clk);
        cyc(6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(6'h00, 5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1);
        // Load-use on rs, R-type
        cyc(6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(6'h00, 5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);
        check_eq("L1.lu_total", 32'(a_cnt), 32'd1);
        check_eq("L3.lu_total", 32'(b_cnt), 32'd3);
        // sw uses rt; lw does not
        cyc(6'h2B, 5'd0, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);
        cyc(6'h23, 5'd0, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        // $zero never stalls
        cyc(6'h00, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Taken branch in RUN
        cyc(6'h04, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        // mem_busy for 4 cycles mid-stall
        cyc(6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(6'h2B, 5'd0, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cyc(6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        check_eq("L3.busy_total", 32'(b_cnt), 32'd7);
        check_eq("L1.busy_total", 32'(a_cnt), 32'd5);
        // Branch during STALL
        cyc(6'h00, 5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        cyc(6'h05, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        // Reset mid-stall
        cyc(6'h00, 5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        // Saturation of the narrow counter, then clear during a freeze
        for (int k = 0; k < 20; k++) cyc(6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("L1.saturated", 32'(a_cnt), 32'd15);
        cyc(6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1);
        check_eq("L1.clr_wins", 32'(a_cnt), 32'd0);
        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            cyc(ops[$urandom_range(0, 5)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 63) == 0));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
